// File: rtl/openmips_pkg.sv
// Shared constants for the openmips integer pipeline: opcode/funct encodings,
// ALU operation enum, datapath widths and the NOP instruction word.
package openmips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct codes (inst[5:0])
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  typedef enum logic [3:0] {
    ALU_NOP,
    ALU_OR,
    ALU_AND,
    ALU_XOR,
    ALU_NOR,
    ALU_LUI,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

endpackage

// File: rtl/openmips_regfile.sv
// 32x32 general-purpose register file: two combinational read ports, one
// synchronous write port, write-through on same-cycle read/write, and
// register 0 hard-wired to zero.
module openmips_regfile
  import openmips_pkg::*;
#(
  parameter int REG_NUM = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0]     rdata1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata2
);

  logic [DATA_W-1:0] regs [REG_NUM];

  // Register storage; writes to register 0 are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1 with write-through bypass
  always_comb begin
    if (raddr1 == '0)                   rdata1 = '0;
    else if (we && (waddr == raddr1))   rdata1 = wdata;
    else                                rdata1 = regs[raddr1];
  end

  // Read port 2 with write-through bypass
  always_comb begin
    if (raddr2 == '0)                   rdata2 = '0;
    else if (we && (waddr == raddr2))   rdata2 = wdata;
    else                                rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/openmips_cpu.sv
// Minimal 5-stage in-order MIPS32 pipeline (IF, ID, EX, MEM, WB) executing
// logical and immediate ALU instructions. No stalls, no flushes; dependent
// instructions are served by EX->ID and MEM->ID forwarding plus register-file
// write-through. Optional macro OPENMIPS_SHIFT_EN adds the SPECIAL shift group.
module openmips_cpu
  import openmips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          REG_NUM  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rom_data_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o
);

  logic [DATA_W-1:0] pc;
  logic              ce;

  // IF/ID
  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] inst_p0;
  // ID/EX
  alu_op_e               alu_op_p1;
  logic [DATA_W-1:0]     src1_p1;
  logic [DATA_W-1:0]     src2_p1;
  logic [REG_ADDR_W-1:0] wd_p1;
  logic                  wreg_p1;
  // EX/MEM
  logic [DATA_W-1:0]     wdata_p2;
  logic [REG_ADDR_W-1:0] wd_p2;
  logic                  wreg_p2;
  // MEM/WB
  logic [DATA_W-1:0]     wdata_p3;
  logic [REG_ADDR_W-1:0] wd_p3;
  logic                  wreg_p3;

  logic [DATA_W-1:0]     ex_result;
  logic [DATA_W-1:0]     rf_rdata1;
  logic [DATA_W-1:0]     rf_rdata2;
  logic [DATA_W-1:0]     rs_val;
  logic [DATA_W-1:0]     rt_val;

  alu_op_e               id_alu_op;
  logic [DATA_W-1:0]     id_src1;
  logic [DATA_W-1:0]     id_src2;
  logic [REG_ADDR_W-1:0] id_wd;
  logic                  id_wreg;

  logic [5:0]            id_opcode;
  logic [5:0]            id_funct;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [15:0]           id_imm;

  logic                  unused_bits;

  function automatic logic [DATA_W-1:0] alu(input alu_op_e op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] b_s;
    b_s = b;
    case (op)
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_XOR: return a ^ b;
      ALU_NOR: return ~(a | b);
      ALU_LUI: return {b[15:0], 16'h0000};
      ALU_SLL: return b << a[4:0];
      ALU_SRL: return b >> a[4:0];
      ALU_SRA: return b_s >>> a[4:0];
      default: return '0;
    endcase
  endfunction

  assign rom_addr_o = pc;
  assign rom_ce_o   = ce;

  // ---- IF: program counter and chip enable; PC holds on the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      ce <= 1'b0;
    end else begin
      ce <= 1'b1;
      if (ce) pc <= pc + 32'd4;
    end
  end

  // ---- IF/ID boundary: latch fetch address and word (NOP while ROM disabled)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0   <= '0;
      inst_p0 <= NOP_INST;
    end else begin
      pc_p0   <= pc;
      inst_p0 <= ce ? rom_data_i : NOP_INST;
    end
  end

  assign id_opcode = inst_p0[31:26];
  assign id_rs     = inst_p0[25:21];
  assign id_rt     = inst_p0[20:16];
  assign id_rd     = inst_p0[15:11];
  assign id_funct  = inst_p0[5:0];
  assign id_imm    = inst_p0[15:0];

  assign unused_bits = ^{pc_p0, inst_p0[10:6]};

  openmips_regfile #(.REG_NUM(REG_NUM)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wreg_p3),
    .waddr  (wd_p3),
    .wdata  (wdata_p3),
    .raddr1 (id_rs),
    .rdata1 (rf_rdata1),
    .raddr2 (id_rt),
    .rdata2 (rf_rdata2)
  );

  // rs operand: EX result beats MEM result beats register file
  always_comb begin
    if (wreg_p1 && (wd_p1 == id_rs) && (id_rs != '0))      rs_val = ex_result;
    else if (wreg_p2 && (wd_p2 == id_rs) && (id_rs != '0)) rs_val = wdata_p2;
    else                                                   rs_val = rf_rdata1;
  end

  // rt operand: same forwarding priority as rs
  always_comb begin
    if (wreg_p1 && (wd_p1 == id_rt) && (id_rt != '0))      rt_val = ex_result;
    else if (wreg_p2 && (wd_p2 == id_rt) && (id_rt != '0)) rt_val = wdata_p2;
    else                                                   rt_val = rf_rdata2;
  end

  // ---- ID: decode, pick destination and form the two ALU operands
  always_comb begin
    id_alu_op = ALU_NOP;
    id_src1   = '0;
    id_src2   = '0;
    id_wd     = '0;
    id_wreg   = 1'b0;
    case (id_opcode)
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        id_wreg = 1'b1;
        id_wd   = id_rt;
        id_src1 = rs_val;
        id_src2 = {16'h0000, id_imm};
        case (id_opcode)
          OP_ORI:  id_alu_op = ALU_OR;
          OP_ANDI: id_alu_op = ALU_AND;
          OP_XORI: id_alu_op = ALU_XOR;
          default: id_alu_op = ALU_LUI;
        endcase
      end
      OP_SPECIAL: begin
        id_wd   = id_rd;
        id_src1 = rs_val;
        id_src2 = rt_val;
        case (id_funct)
          F_AND: begin id_alu_op = ALU_AND; id_wreg = 1'b1; end
          F_OR:  begin id_alu_op = ALU_OR;  id_wreg = 1'b1; end
          F_XOR: begin id_alu_op = ALU_XOR; id_wreg = 1'b1; end
          F_NOR: begin id_alu_op = ALU_NOR; id_wreg = 1'b1; end
`ifdef OPENMIPS_SHIFT_EN
          // Immediate shifts take shamt; variable shifts take rs[4:0]
          F_SLL: begin id_alu_op = ALU_SLL; id_wreg = 1'b1; id_src1 = {27'd0, inst_p0[10:6]}; end
          F_SRL: begin id_alu_op = ALU_SRL; id_wreg = 1'b1; id_src1 = {27'd0, inst_p0[10:6]}; end
          F_SRA: begin id_alu_op = ALU_SRA; id_wreg = 1'b1; id_src1 = {27'd0, inst_p0[10:6]}; end
          F_SLLV: begin id_alu_op = ALU_SLL; id_wreg = 1'b1; id_src1 = {27'd0, rs_val[4:0]}; end
          F_SRLV: begin id_alu_op = ALU_SRL; id_wreg = 1'b1; id_src1 = {27'd0, rs_val[4:0]}; end
          F_SRAV: begin id_alu_op = ALU_SRA; id_wreg = 1'b1; id_src1 = {27'd0, rs_val[4:0]}; end
`else
`endif
          default: begin
            id_alu_op = ALU_NOP;
            id_wreg   = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

  // ---- ID/EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_p1 <= ALU_NOP;
      src1_p1   <= '0;
      src2_p1   <= '0;
      wd_p1     <= '0;
      wreg_p1   <= 1'b0;
    end else begin
      alu_op_p1 <= id_alu_op;
      src1_p1   <= id_src1;
      src2_p1   <= id_src2;
      wd_p1     <= id_wd;
      wreg_p1   <= id_wreg;
    end
  end

  assign ex_result = alu(alu_op_p1, src1_p1, src2_p1);

  // ---- EX/MEM boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata_p2 <= '0;
      wd_p2    <= '0;
      wreg_p2  <= 1'b0;
    end else begin
      wdata_p2 <= ex_result;
      wd_p2    <= wd_p1;
      wreg_p2  <= wreg_p1;
    end
  end

  // ---- MEM/WB boundary: MEM has no data memory, results pass straight through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata_p3 <= '0;
      wd_p3    <= '0;
      wreg_p3  <= 1'b0;
    end else begin
      wdata_p3 <= wdata_p2;
      wd_p3    <= wd_p2;
      wreg_p3  <= wreg_p2;
    end
  end

endmodule

// File: tb/tb_openmips_cpu.sv
// Directed testbench for openmips_cpu: behavioural ROM, table of
// {program, edge, register, expected value} records, plus hand-written
// sequences for fetch timing and reset asserted mid-run.
module tb_openmips_cpu;

  logic        clk;
  logic        rst;
  logic [31:0] rom_data;
  logic [31:0] rom_addr;
  logic        rom_ce;

  logic [31:0] mem   [16];
  logic [31:0] progs [4][16];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_edge = 0;
  int loaded   = 0;

  typedef struct {
    int          prog;
    int          at_edge;
    int          regi;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  openmips_cpu #(.RESET_PC(32'h0000_0000), .REG_NUM(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_data_i (rom_data),
    .rom_addr_o (rom_addr),
    .rom_ce_o   (rom_ce)
  );

  // Combinational ROM: word-addressed, zero when disabled or out of range
  assign rom_data = (rom_ce && (rom_addr[31:6] == 26'd0)) ? mem[rom_addr[5:2]] : 32'h0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 16; i++) mem[i] = progs[p][i];
    loaded = p;
  endtask

  // Advance to edge k after E0, sampling 1 ns past the edge
  task automatic goto_edge(input int k);
    while (cur_edge < k) begin
      @(posedge clk);
      #1;
      cur_edge++;
    end
  endtask

  // Release reset between edges, then consume E0
  task automatic release_reset();
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    cur_edge = 0;
  endtask

  task automatic restart(input int p);
    rst = 1'b1;
    load_prog(p);
    release_reset();
  endtask

  function automatic void add(input int p, input int e, input int r, input logic [31:0] x);
    vec_t v;
    v.prog = p; v.at_edge = e; v.regi = r; v.exp = x;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] any_nonzero;

    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 16; i++) progs[p][i] = 32'h0;
    // Independent ORI
    progs[0][0] = 32'h34011100; progs[0][1] = 32'h34020020;
    progs[0][2] = 32'h3403ff00; progs[0][3] = 32'h3404ffff;
    // Forwarding chain on $1
    progs[1][0] = 32'h34011100; progs[1][1] = 32'h34210020;
    progs[1][2] = 32'h34214400; progs[1][3] = 32'h34210044;
    // Mixed logic: LUI, ORI, ANDI, NOR, XOR, AND, XORI, OR
    progs[2][0] = 32'h3C010101; progs[2][1] = 32'h34210101;
    progs[2][2] = 32'h302300FE; progs[2][3] = 32'h00202027;
    progs[2][4] = 32'h00242826; progs[2][5] = 32'h00A13824;
    progs[2][6] = 32'h38880F0F; progs[2][7] = 32'h00883025;
    // Register 0 and an unsupported opcode (ADDI $9,$0,5)
    progs[3][0] = 32'h3400FFFF; progs[3][1] = 32'h34010000;
    progs[3][2] = 32'h20090005;

    add(0, 4, 1, 32'h00000000);
    add(0, 5, 1, 32'h00001100);
    add(0, 6, 2, 32'h00000020);
    add(0, 7, 3, 32'h0000ff00);
    add(0, 8, 4, 32'h0000ffff);
    add(1, 5, 1, 32'h00001100);
    add(1, 6, 1, 32'h00001120);
    add(1, 7, 1, 32'h00005520);
    add(1, 8, 1, 32'h00005564);
    add(2, 5, 1, 32'h01010000);
    add(2, 6, 1, 32'h01010101);
    add(2, 7, 3, 32'h00000000);
    add(2, 8, 4, 32'hfefefefe);
    add(2, 9, 5, 32'hffffffff);
    add(2, 10, 7, 32'h01010101);
    add(2, 11, 8, 32'hfefef1f1);
    add(2, 12, 6, 32'hfefeffff);
    add(3, 5, 0, 32'h00000000);
    add(3, 6, 1, 32'h00000000);
    add(3, 7, 9, 32'h00000000);

    // Power-on reset and fetch sequence
    rst = 1'b1;
    load_prog(0);
    #40;
    check("reset_ce", {31'd0, rom_ce}, 32'd0);
    check("reset_addr", rom_addr, 32'h0);
    #33 rst = 1'b0;
    @(posedge clk);
    #1;
    cur_edge = 0;
    check("e0_ce", {31'd0, rom_ce}, 32'd1);
    check("e0_addr", rom_addr, 32'h0);
    goto_edge(1); check("e1_addr", rom_addr, 32'd4);
    goto_edge(2); check("e2_addr", rom_addr, 32'd8);
    goto_edge(3); check("e3_addr", rom_addr, 32'd12);

    // Table-driven register checks
    foreach (vecs[i]) begin
      if (vecs[i].prog != loaded || vecs[i].at_edge < cur_edge) restart(vecs[i].prog);
      goto_edge(vecs[i].at_edge);
      check($sformatf("prog%0d_e%0d_r%0d", vecs[i].prog, vecs[i].at_edge, vecs[i].regi),
            dut.u_regfile.regs[vecs[i].regi], vecs[i].exp);
    end

    // Reset asserted in the middle of the forwarding chain
    restart(1);
    goto_edge(6);
    check("midrst_pre_r1", dut.u_regfile.regs[1], 32'h00001120);
    rst = 1'b1;
    #2;
    any_nonzero = 32'h0;
    for (int r = 0; r < 32; r++) any_nonzero = any_nonzero | dut.u_regfile.regs[r];
    check("midrst_gprs_or", any_nonzero, 32'h0);
    check("midrst_addr", rom_addr, 32'h0);
    check("midrst_ce", {31'd0, rom_ce}, 32'd0);
    release_reset();
    check("midrst_e0_addr", rom_addr, 32'h0);
    goto_edge(1); check("midrst_e1_addr", rom_addr, 32'd4);
    goto_edge(4); check("midrst_e4_r1", dut.u_regfile.regs[1], 32'h00000000);
    goto_edge(5); check("midrst_e5_r1", dut.u_regfile.regs[1], 32'h00001100);
    goto_edge(6); check("midrst_e6_r1", dut.u_regfile.regs[1], 32'h00001120);
    goto_edge(7); check("midrst_e7_r1", dut.u_regfile.regs[1], 32'h00005520);
    goto_edge(8); check("midrst_e8_r1", dut.u_regfile.regs[1], 32'h00005564);
    goto_edge(9); check("midrst_e9_addr", rom_addr, 32'd36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
